// File: rtl/tc_wb_collect_pkg.sv
// Shared types and widths for the tensor-core writeback collector.
// The warp-id width normally comes from the project-wide define.v.
`ifndef DEPTH_WARP
`define DEPTH_WARP 4
`endif

package tc_wb_collect_pkg;

  localparam int DEF_EXPWIDTH  = 8;
  localparam int DEF_PRECISION = 24;
  localparam int DEF_NUM_ELEM  = 4;

  localparam int FFLAGS_W  = 5;
  localparam int REG_IDX_W = 8;
  localparam int WARP_W    = `DEPTH_WARP;
  localparam int TAG_W     = WARP_W + REG_IDX_W;

  typedef enum logic [1:0] {
    BUF_IDLE,
    BUF_APPEND,
    BUF_RESTART,
    BUF_CLEAR
  } buf_cmd_e;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_APPEND,
    ACT_CLOSE_FULL,
    ACT_CLOSE_SPLIT,
    ACT_FLUSH
  } wb_act_e;

  function automatic int elem_len(input int expwidth, input int precision);
    return expwidth + precision;
  endfunction

  function automatic int cnt_width(input int num_elem);
    return $clog2(num_elem + 1);
  endfunction

endpackage

// File: rtl/tc_wb_slot_buf.sv
// Collection buffer: element slots, fill count, group tag and OR-ed fflags.
// Slots above the fill count are always zero, so partial groups need no masking.
`ifndef DEPTH_WARP
`define DEPTH_WARP 4
`endif

module tc_wb_slot_buf
  import tc_wb_collect_pkg::*;
#(
  parameter int LEN      = 32,
  parameter int NUM_ELEM = 4,
  parameter int CNT_W    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              cmd_i,
  input  logic [LEN-1:0]          elem_i,
  input  logic [FFLAGS_W-1:0]     fflags_i,
  input  logic [TAG_W-1:0]        tag_i,
  output logic [CNT_W-1:0]        count_o,
  output logic [NUM_ELEM*LEN-1:0] slots_o,
  output logic [TAG_W-1:0]        tag_o,
  output logic [FFLAGS_W-1:0]     acc_o
);

  buf_cmd_e             cmd;
  logic [LEN-1:0]       slot_q [NUM_ELEM];
  logic [CNT_W-1:0]     count_q;
  logic [TAG_W-1:0]     tag_q;
  logic [FFLAGS_W-1:0]  acc_q;

  assign cmd = buf_cmd_e'(cmd_i);

  // RESTART seeds a new group with the element that broke the old one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tag_q   <= '0;
      acc_q   <= '0;
      for (int k = 0; k < NUM_ELEM; k++) slot_q[k] <= '0;
    end else begin
      case (cmd)
        BUF_APPEND: begin
          for (int k = 0; k < NUM_ELEM; k++)
            if (count_q == CNT_W'(k)) slot_q[k] <= elem_i;
          count_q <= count_q + CNT_W'(1);
          tag_q   <= tag_i;
          acc_q   <= acc_q | fflags_i;
        end
        BUF_RESTART: begin
          for (int k = 0; k < NUM_ELEM; k++)
            slot_q[k] <= (k == 0) ? elem_i : '0;
          count_q <= CNT_W'(1);
          tag_q   <= tag_i;
          acc_q   <= fflags_i;
        end
        BUF_CLEAR: begin
          for (int k = 0; k < NUM_ELEM; k++) slot_q[k] <= '0;
          count_q <= '0;
          tag_q   <= '0;
          acc_q   <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    slots_o = '0;
    for (int k = 0; k < NUM_ELEM; k++) slots_o[k*LEN +: LEN] = slot_q[k];
  end

  assign count_o = count_q;
  assign tag_o   = tag_q;
  assign acc_o   = acc_q;

endmodule

// File: rtl/tc_wb_collect.sv
// Packs consecutive same-tag add-pipe results into vector register writebacks,
// closing groups when full, on a tag change, or on flush.
`ifndef DEPTH_WARP
`define DEPTH_WARP 4
`endif

module tc_wb_collect
  import tc_wb_collect_pkg::*;
#(
  parameter int EXPWIDTH  = DEF_EXPWIDTH,
  parameter int PRECISION = DEF_PRECISION,
  parameter int NUM_ELEM  = DEF_NUM_ELEM
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic [EXPWIDTH+PRECISION-1:0]          result_i,
  input  logic [4:0]                             fflags_i,
  input  logic [7:0]                             ctrl_reg_idxw_i,
  input  logic [`DEPTH_WARP-1:0]                 ctrl_warpid_i,
  input  logic                                   flush_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [NUM_ELEM*(EXPWIDTH+PRECISION)-1:0] wb_data_o,
  output logic [NUM_ELEM-1:0]                    wb_mask_o,
  output logic [4:0]                             wb_fflags_o,
  output logic [7:0]                             wb_reg_idxw_o,
  output logic [`DEPTH_WARP-1:0]                 wb_warpid_o,
  output logic                                   busy_o
);

  localparam int LEN    = elem_len(EXPWIDTH, PRECISION);
  localparam int CNT_W  = cnt_width(NUM_ELEM);
  localparam int DATA_W = NUM_ELEM * LEN;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ELEM - 1);

  logic [TAG_W-1:0]    in_tag;
  logic [TAG_W-1:0]    buf_tag;
  logic [CNT_W-1:0]    buf_count;
  logic [DATA_W-1:0]   buf_slots;
  logic [FFLAGS_W-1:0] buf_acc;

  logic out_free, mismatch, last_slot, closes, accept;
  wb_act_e  act;
  buf_cmd_e buf_cmd;

  logic [NUM_ELEM-1:0] part_mask;
  logic [DATA_W-1:0]   part_data, full_data;
  logic                load;
  logic [DATA_W-1:0]   load_data;
  logic [NUM_ELEM-1:0] load_mask;
  logic [FFLAGS_W-1:0] load_fflags;
  logic [TAG_W-1:0]    load_tag;

  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [NUM_ELEM-1:0] out_mask_q;
  logic [FFLAGS_W-1:0] out_fflags_q;
  logic [TAG_W-1:0]    out_tag_q;
  logic                flush_pend_q;

  assign in_tag    = {ctrl_warpid_i, ctrl_reg_idxw_i};
  assign out_free  = !out_valid_q || out_ready_i;
  assign mismatch  = (buf_count != '0) && (in_tag != buf_tag);
  assign last_slot = (buf_count == LAST_CNT);
  assign closes    = mismatch || last_slot;
  // Only a closing element needs room in the output register.
  assign in_ready_o = out_free || !closes;
  assign accept     = in_valid_i && in_ready_o;

  tc_wb_slot_buf #(
    .LEN      (LEN),
    .NUM_ELEM (NUM_ELEM),
    .CNT_W    (CNT_W)
  ) u_slot_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_i    (buf_cmd),
    .elem_i   (result_i),
    .fflags_i (fflags_i),
    .tag_i    (in_tag),
    .count_o  (buf_count),
    .slots_o  (buf_slots),
    .tag_o    (buf_tag),
    .acc_o    (buf_acc)
  );

  // An accepted element always wins over a pending flush.
  always_comb begin
    act     = ACT_NONE;
    buf_cmd = BUF_IDLE;
    if (accept) begin
      if (mismatch) begin
        act     = ACT_CLOSE_SPLIT;
        buf_cmd = BUF_RESTART;
      end else if (last_slot) begin
        act     = ACT_CLOSE_FULL;
        buf_cmd = BUF_CLEAR;
      end else begin
        act     = ACT_APPEND;
        buf_cmd = BUF_APPEND;
      end
    end else if (flush_pend_q && (buf_count != '0) && out_free) begin
      act     = ACT_FLUSH;
      buf_cmd = BUF_CLEAR;
    end
  end

  always_comb begin
    part_mask = '0;
    part_data = '0;
    for (int k = 0; k < NUM_ELEM; k++) begin
      if (k < int'(buf_count)) begin
        part_mask[k]            = 1'b1;
        part_data[k*LEN +: LEN] = buf_slots[k*LEN +: LEN];
      end
    end
    full_data = buf_slots;
    full_data[(NUM_ELEM-1)*LEN +: LEN] = result_i;

    load        = 1'b0;
    load_data   = '0;
    load_mask   = '0;
    load_fflags = '0;
    load_tag    = '0;
    case (act)
      ACT_CLOSE_FULL: begin
        load        = 1'b1;
        load_data   = full_data;
        load_mask   = '1;
        load_fflags = buf_acc | fflags_i;
        load_tag    = in_tag;
      end
      ACT_CLOSE_SPLIT, ACT_FLUSH: begin
        load        = 1'b1;
        load_data   = part_data;
        load_mask   = part_mask;
        load_fflags = buf_acc;
        load_tag    = buf_tag;
      end
      default: ;
    endcase
  end

  // A load on the same edge as a handshake keeps valid high with new content.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_mask_q   <= '0;
      out_fflags_q <= '0;
      out_tag_q    <= '0;
    end else if (load) begin
      out_valid_q  <= 1'b1;
      out_data_q   <= load_data;
      out_mask_q   <= load_mask;
      out_fflags_q <= load_fflags;
      out_tag_q    <= load_tag;
    end else if (out_ready_i) begin
      out_valid_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend_q <= 1'b0;
    end else if (flush_i) begin
      flush_pend_q <= 1'b1;
    end else if ((act == ACT_FLUSH) || (flush_pend_q && !accept && (buf_count == '0))) begin
      flush_pend_q <= 1'b0;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign wb_data_o     = out_data_q;
  assign wb_mask_o     = out_mask_q;
  assign wb_fflags_o   = out_fflags_q;
  assign wb_reg_idxw_o = out_tag_q[REG_IDX_W-1:0];
  assign wb_warpid_o   = out_tag_q[TAG_W-1 -: WARP_W];
  assign busy_o        = (buf_count != '0) || out_valid_q || flush_pend_q;

endmodule
